bcd_down_timer: RTL and testbench
=================================

// Module: bcd_down_timer
// PURPOSE
//  Multi-digit BCD countdown timer; counting mirror of the mod-10 up-counter digits.
//  Loads a BCD preset, then decrements once per dec strobe with borrow ripple across digits.
//  Flags terminal zero. Feeds the seven-segment display path.
//  dec is driven by the shared 1 Hz / 100 Hz tick generator.
// PARAMETERS
//  DIGITS   4  number of BCD digits (1..8); count width W = 4*DIGITS
// PORTS
//  clk       in   1    system clock, all state on rising edge
//  rst       in   1    reset, asynchronous, active-low (0 = reset)
//  load      in   1    load load_val into count, go IDLE
//  load_val  in   W    BCD preset, digit 0 = [3:0]
//  start     in   1    begin/resume counting
//  pause     in   1    suspend counting (count held)
//  dec       in   1    decrement strobe, honoured only in RUN
//  count     out  W    current BCD value
//  zero      out  1    count == 0 (combinational from count)
//  running   out  1    state == RUN
//  done      out  1    one-cycle pulse on RUN->DONE transition
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, state=IDLE, running=0, done=0, zero=1.
//  - States: IDLE, RUN, PAUSE, DONE.
//  - Per-cycle input priority: load > pause > start > dec.
//    - load: any state -> IDLE; count<=load_val; digits >9 are clamped to 9.
//    - pause: RUN -> PAUSE; ignored in other states.
//    - start: IDLE/PAUSE -> RUN if count!=0; ignored if count==0 or state==DONE.
//    - dec in RUN: digit0-1. A digit at 0 becomes 9 and borrows into the next digit.
//  - Latency: count updates the cycle after the dec edge; no combinational input->count path.
//  - Terminal: dec in RUN when count==1 (all upper digits 0) -> count=0, state=DONE.
//    done=1 for exactly that next cycle.
//  - DONE: count held at 0. Leave only via load or reset. dec/start/pause ignored.
//  - Underflow never occurs: dec is ignored at count==0 in every state.
//  - dec in IDLE/PAUSE: ignored, count unchanged.
//  - Borrow wrap: 1000 -> 0999 in one dec. Only digit0's decrement is conditional on dec;
//    higher digits change only on borrow-in.
//  - Reset mid-RUN: immediate async clear. The cycle after release is IDLE with count 0.
// CONFIGURATION
//  - BCD_TIMER_AUTORELOAD_EN defined:
//    - load_val is also captured into reload register rl (reset 0).
//    - On the terminal dec: count<=rl, state stays RUN, done pulses, running stays 1.
//    - If rl==0, enter DONE as in the non-reload build.
//  - Undefined: no reload register; terminal dec enters DONE as above.
// STRUCTURE
//  - Shared include bcd_timer_pkg.vh:
//    - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3
//    - BCD_MAX=4'd9
//  - Sub-module bcd_down_digit, instantiated DIGITS times via generate:
//    - inputs: clk, rst, ld, ld_val[3:0], bin (borrow-in/decrement enable)
//    - outputs: q[3:0], bout = bin & (q==0)
//    - bin of digit0 = dec & RUN & !zero; bin of digit k = bout of digit k-1.
//  - Top: FSM, priority decode, done pulse register, reload register (macro-guarded).
// TESTING
//  1. Reset: assert rst=0 mid-count at 0042 -> count=0000, IDLE, zero=1 same cycle.
//     Release rst -> state holds.
//  2. Load 0012, start, 12 dec strobes:
//     - count steps 0011..0000
//     - done=1 for one cycle after the 12th dec
//     - state DONE; further dec leaves 0000
//  3. Borrow chain: load 1000, start, 1 dec -> 0999. Load 0100, 1 dec -> 0099.
//  4. Priority:
//     - load 0050 with pause+start+dec same cycle -> count 0050, IDLE
//     - in RUN, pause+dec same cycle -> PAUSE, count unchanged
//  5. Edge cases:
//     - start with count 0000 -> stays IDLE
//     - load_val 00A3 -> count 0093
//     - dec while PAUSE -> no change
//  6. AUTORELOAD_EN build: load 0002, start, 4 dec -> 0001, 0002(done), 0001, 0002(done).
//     running stays 1 throughout.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer_pkg
//  Description : Shared definitions for the BCD countdown timer: FSM state
//                encodings, the largest legal BCD digit and a digit clamp.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-decimal nibbles (A..F) saturate to 9 so a bad preset stays valid BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_digit
//  Description : One BCD countdown digit. Loads a preset, or steps down by one
//                when borrow-in is set, wrapping 0 -> 9 and borrowing onward.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       bin,
  output logic [3:0] q,
  output logic       bout
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: a load overrides any decrement in the same cycle.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (bin) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
    end
  end

  // Digit register, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign bout = bin & (q_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bcd_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_timer
//  Description : Multi-digit BCD countdown timer with IDLE/RUN/PAUSE/DONE
//                control, terminal-zero flag and one-cycle done pulse.
//                Optional feature macro: BCD_TIMER_AUTORELOAD_EN -- reload the
//                last preset on the terminal decrement and keep running.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                dec,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                running,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  state_e         state_q, state_d;
  logic           done_q, done_d;
  logic [W-1:0]   count_w;
  logic [W-1:0]   clamped_w;
  logic [W-1:0]   digit_ld_val_w;
  logic           digit_ld_w;
  logic [DIGITS:0] borrow_w;
  logic           pause_act_w, start_act_w, dec_en_w, terminal_w, reload_fire_w;
  logic           w_unused_borrow;

  // Saturate every preset nibble to a legal BCD digit.
  always_comb begin
    clamped_w = '0;
    for (int k = 0; k < DIGITS; k++) begin
      clamped_w[4*k +: 4] = bcd_clamp(load_val[4*k +: 4]);
    end
  end

  assign zero = (count_w == '0);

  // A lower-priority command is considered only when no higher one acts.
  assign pause_act_w = ~load & pause & (state_q == ST_RUN);
  assign start_act_w = ~load & start & ~zero &
                       ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
  assign dec_en_w    = ~load & ~pause_act_w & ~start_act_w & dec &
                       (state_q == ST_RUN) & ~zero;
  assign terminal_w  = dec_en_w & (count_w == W'(1));

`ifdef BCD_TIMER_AUTORELOAD_EN
  logic [W-1:0] rl_q;

  // Reload register remembers the most recent (clamped) preset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rl_q <= '0;
    end else if (load) begin
      rl_q <= clamped_w;
    end
  end

  assign reload_fire_w  = terminal_w & (rl_q != '0);
  assign digit_ld_w     = load | reload_fire_w;
  assign digit_ld_val_w = load ? clamped_w : rl_q;
`else
  assign reload_fire_w  = 1'b0;
  assign digit_ld_w     = load;
  assign digit_ld_val_w = clamped_w;
`endif

  // Next state and done pulse; done is registered so it lands after the edge.
  always_comb begin
    state_d = state_q;
    done_d  = terminal_w;
    if (load) begin
      state_d = ST_IDLE;
    end else if (pause_act_w) begin
      state_d = ST_PAUSE;
    end else if (start_act_w) begin
      state_d = ST_RUN;
    end else if (terminal_w && !reload_fire_w) begin
      state_d = ST_DONE;
    end
  end

  // State and done-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Borrow ripple: only digit 0 sees the gated strobe, the rest chain on it.
  assign borrow_w[0] = dec_en_w;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_down_digit u_digit (
        .clk    (clk),
        .rst    (rst),
        .ld     (digit_ld_w),
        .ld_val (digit_ld_val_w[4*k +: 4]),
        .bin    (borrow_w[k]),
        .q      (count_w[4*k +: 4]),
        .bout   (borrow_w[k+1])
      );
    end
  endgenerate

  // The top digit's borrow-out has no consumer: decrement is blocked at zero.
  assign w_unused_borrow = borrow_w[DIGITS];

  assign count   = count_w;
  assign running = (state_q == ST_RUN);
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_down_timer
//  Description : Self-checking bench for bcd_down_timer: directed scenarios
//                plus random commands against a decimal reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start    = 1'b0;
  logic         pause    = 1'b0;
  logic         dec      = 1'b0;
  logic [W-1:0] count;
  logic         zero, running, done;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .dec      (dec),
    .count    (count),
    .zero     (zero),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] count;
    logic         zero;
    logic         running;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain decimal value and a state number.
  longint m_val = 0;
  longint m_rl  = 0;
  int     m_st  = M_IDLE;

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r;
    longint       t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint preset_value(input logic [W-1:0] raw);
    longint v, p;
    int     d;
    v = 0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(raw[4*k +: 4]);
      if (d > 9) d = 9;
      v = v + longint'(d) * p;
      p = p * 10;
    end
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic cycle(input logic l, input logic [W-1:0] lv,
                       input logic s, input logic p, input logic d);
    exp_t e;
    logic term;
    @(negedge clk);
    load = l; load_val = lv; start = s; pause = p; dec = d;
    term = 1'b0;
    if (l) begin
      m_val = preset_value(lv);
      m_rl  = m_val;
      m_st  = M_IDLE;
    end else if (p && m_st == M_RUN) begin
      m_st = M_PAUSE;
    end else if (s && (m_st == M_IDLE || m_st == M_PAUSE) && m_val != 0) begin
      m_st = M_RUN;
    end else if (d && m_st == M_RUN && m_val != 0) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        term = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
        if (m_rl != 0) m_val = m_rl;
        else           m_st  = M_DONE;
`else
        m_st = M_DONE;
`endif
      end
    end
    e.count   = to_bcd(m_val);
    e.zero    = (m_val == 0);
    e.running = (m_st == M_RUN);
    e.done    = term;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest entry.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count !== e.count || zero !== e.zero ||
          running !== e.running || done !== e.done) begin
        errors++;
        $display("FAIL outputs t=%0t: got count=%h zero=%b running=%b done=%b, expected count=%h zero=%b running=%b done=%b",
                 $time, count, zero, running, done, e.count, e.zero, e.running, e.done);
      end
    end
  end

  task automatic check_reset_state(input string name);
    checks++;
    if (count !== '0 || zero !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got count=%h zero=%b running=%b done=%b, expected count=0000 zero=1 running=0 done=0",
               name, count, zero, running, done);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] lv;
    int           r;

    // Power-on reset.
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of a count.
    cycle(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("async_reset");
    m_val = 0; m_rl = 0; m_st = M_IDLE;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // 0012 counted to terminal, then extra strobes.
    cycle(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(12);
    tick(3);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Borrow chains.
    cycle(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(1);
    cycle(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(1);

    // Priority: load beats everything; pause beats dec in RUN.
    cycle(1'b1, 16'h0050, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick(2);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(1);

    // Edge cases: start at zero, non-BCD preset, short reload run.
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h00A3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(4);

    // Random command mix.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       lv = to_bcd(longint'($urandom_range(0, 20)));
        1:       lv = to_bcd(longint'($urandom_range(0, 9999)));
        2:       lv = W'($urandom);
        default: lv = '0;
      endcase
      cycle(($urandom_range(0, 99) < 3),  lv,
            ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 45));
    end

    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
